// File: rtl/wb_stage_ll_pkg.sv
// Shared constants for the write-back stage: datapath defaults,
// result-source encodings and load funct3 codes.
package wb_stage_ll_pkg;

  localparam int WB_WORD_SIZE  = 32;
  localparam int WB_REG_ADDR_W = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/wb_stage_ll_fifo.sv
// Synchronous FIFO buffering long-latency results.
// Pointers carry an extra wrap bit so full and empty are distinct.
module wb_ll_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/wb_stage_ll.sv
// Write-back stage: main-pipe result select/extend plus a buffered
// long-latency result queue that retires into idle write-port slots.
module wb_stage_ll
  import wb_stage_ll_pkg::*;
#(
  parameter int WORD_SIZE  = WB_WORD_SIZE,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int LL_DEPTH   = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_SIZE-1:0]      ALUResultW,
  input  logic [WORD_SIZE-1:0]      ReadDataW,
  input  logic [WORD_SIZE-1:0]      PCPlus4W,
  input  logic [WORD_SIZE-1:0]      ImmExtW,
  input  logic [1:0]                ResultSrcW,
  input  logic [2:0]                LoadTypeW,
  input  logic [1:0]                ByteOffW,
  input  logic [REG_ADDR_W-1:0]     RdW,
  input  logic                      RegWriteW,
  input  logic                      LlValid,
  output logic                      LlReady,
  input  logic [REG_ADDR_W-1:0]     LlRd,
  input  logic [WORD_SIZE-1:0]      LlData,
  output logic                      RfWe,
  output logic [REG_ADDR_W-1:0]     RfRd,
  output logic [WORD_SIZE-1:0]      RfData,
  output logic                      StallReq,
  output logic [$clog2(LL_DEPTH):0] LlPending
);

  localparam int CW = $clog2(LL_DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int EW = REG_ADDR_W + WORD_SIZE;

  logic [WORD_SIZE-1:0] shifted, ld_val, main_val;
  logic                 main_act, push, pop, full, empty;
  logic [EW-1:0]        head;
  logic [CW-1:0]        count;
  logic [WW-1:0]        wait_q, wait_d;

  always_comb begin
    shifted = ReadDataW >> {ByteOffW, 3'b000};
    case (LoadTypeW)
      LD_B:  ld_val = {{(WORD_SIZE-8){shifted[7]}}, shifted[7:0]};
      LD_H:  ld_val = {{(WORD_SIZE-16){shifted[15]}}, shifted[15:0]};
      LD_BU: ld_val = {{(WORD_SIZE-8){1'b0}}, shifted[7:0]};
      LD_HU: ld_val = {{(WORD_SIZE-16){1'b0}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  always_comb begin
    main_val = ALUResultW;
    unique case (ResultSrcW)
      RES_ALU: main_val = ALUResultW;
      RES_MEM: main_val = ld_val;
      RES_PC4: main_val = PCPlus4W;
      RES_IMM: main_val = ImmExtW;
    endcase
  end

  assign main_act = RegWriteW && (RdW != '0);
  assign LlReady  = !rst && !full;
  // Rd=0 transfers are handshaken but never stored.
  assign push     = LlValid && LlReady && (LlRd != '0);
  assign pop      = !rst && !main_act && !empty;

  wb_ll_fifo #(
    .WIDTH(EW),
    .DEPTH(LL_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({LlRd, LlData}),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  always_comb begin
    RfWe   = 1'b0;
    RfRd   = '0;
    RfData = '0;
    if (main_act && !rst) begin
      RfWe   = 1'b1;
      RfRd   = RdW;
      RfData = main_val;
    end else if (pop) begin
      RfWe           = 1'b1;
      {RfRd, RfData} = head;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (pop || empty)
      wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT))
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  assign StallReq  = !rst && !empty && (wait_q == WW'(MAX_WAIT));
  assign LlPending = rst ? '0 : count;

endmodule
